// File: rtl/msrh_brtag_alloc_pkg.sv
// Configuration and shared branch-tag types for the branch tag allocator.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package msrh_conf_pkg;
    localparam int RV_BRU_ENTRY_SIZE = 16;
    localparam int DISP_SIZE         = 5;
endpackage

package msrh_pkg;
    import msrh_conf_pkg::*;

    localparam int BRTAG_W    = $clog2(RV_BRU_ENTRY_SIZE);
    localparam int FREE_CNT_W = $clog2(RV_BRU_ENTRY_SIZE) + 1;

    typedef logic [BRTAG_W-1:0]           brtag_t;
    typedef logic [RV_BRU_ENTRY_SIZE-1:0] brmask_t;

    // Branch resolution reported by the BRU.
    typedef struct packed {
        logic   update;
        logic   mispredict;
        logic   dead;
        brtag_t brtag;
    } br_upd_t;

    // Per-slot branch commit from the ROB.
    typedef struct packed {
        logic                          commit;
        logic [DISP_SIZE-1:0]          is_br_inst;
        brtag_t [DISP_SIZE-1:0]        brtag;
    } cmt_brtag_t;

    // Number of set bits in a tag-wide vector (narrower vectors are zero-extended by the caller).
    function automatic int unsigned popcount(input brmask_t v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < RV_BRU_ENTRY_SIZE; i++) begin
            cnt += int'(v[i]);
        end
        return cnt;
    endfunction
endpackage

// File: rtl/msrh_brtag_alloc_pick.sv
// Multi-way lowest-index-first free-bit picker: one distinct free bit per requesting slot.
// Latency: purely combinational.
// Backpressure: none; a requesting slot with no free bit left gets grant_vld=0.
module msrh_brtag_pick #(
    parameter int ENTRY_SIZE = 16,
    parameter int DISP_SIZE  = 5
) (
    input  logic [ENTRY_SIZE-1:0]                free_vec,
    input  logic [DISP_SIZE-1:0]                 req,
    output logic [DISP_SIZE-1:0][ENTRY_SIZE-1:0] grant_oh,
    output logic [DISP_SIZE-1:0]                 grant_vld
);

    logic [ENTRY_SIZE-1:0] avail;
    logic                  found;

    // Walk slots in ascending order; each requesting slot takes the lowest bit still available.
    always_comb begin
        avail     = free_vec;
        found     = 1'b0;
        grant_oh  = '0;
        grant_vld = '0;
        for (int i = 0; i < DISP_SIZE; i++) begin
            found = 1'b0;
            if (req[i]) begin
                for (int t = 0; t < ENTRY_SIZE; t++) begin
                    if (!found && avail[t]) begin
                        grant_oh[i][t] = 1'b1;
                        found          = 1'b1;
                    end
                end
            end
            grant_vld[i] = found;
            avail        = avail & ~grant_oh[i];
        end
    end

endmodule

// File: rtl/msrh_brtag_alloc.sv
// Branch tag allocator: hands out tags and older-branch masks at dispatch, frees on kill/commit.
// Latency: tag/mask combinational in the dispatch cycle; state and free count update next cycle.
// Backpressure: o_disp_ready drops when free tags < branches in group, or during a mispredict cycle.
module msrh_brtag_alloc
    import msrh_pkg::*;
#(
    parameter int ENTRY_SIZE = msrh_conf_pkg::RV_BRU_ENTRY_SIZE,
    parameter int DISP_SIZE  = msrh_conf_pkg::DISP_SIZE
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_disp_valid,
    input  logic [DISP_SIZE-1:0]          i_disp_is_br,
    output logic                          o_disp_ready,
    output brtag_t  [DISP_SIZE-1:0]       o_disp_brtag,
    output brmask_t [DISP_SIZE-1:0]       o_disp_br_mask,
    input  br_upd_t                       br_upd_if,
    input  cmt_brtag_t                    cmt_brtag_if,
    output logic [$clog2(ENTRY_SIZE):0]   o_free_count
);

    localparam int CNT_W = $clog2(ENTRY_SIZE) + 1;

    logic [ENTRY_SIZE-1:0]                 r_alloc;
    logic [ENTRY_SIZE-1:0]                 r_unres;
    logic [ENTRY_SIZE-1:0][ENTRY_SIZE-1:0] r_dep;
    logic [CNT_W-1:0]                      r_free_count;

    logic [ENTRY_SIZE-1:0]                 w_alloc;
    logic [ENTRY_SIZE-1:0]                 w_unres;
    logic [ENTRY_SIZE-1:0][ENTRY_SIZE-1:0] w_dep;
    logic [CNT_W-1:0]                      w_free_count;

    logic [DISP_SIZE-1:0][ENTRY_SIZE-1:0]  grant_oh;
    logic [DISP_SIZE-1:0]                  grant_vld;
    logic [ENTRY_SIZE-1:0]                 mask_run;
    logic [CNT_W-1:0]                      n_br;
    logic                                  resolve;
    logic                                  kill_cyc;
    logic                                  accept;

    msrh_brtag_pick #(
        .ENTRY_SIZE (ENTRY_SIZE),
        .DISP_SIZE  (DISP_SIZE)
    ) u_pick (
        .free_vec  (~r_alloc),
        .req       (i_disp_is_br),
        .grant_oh  (grant_oh),
        .grant_vld (grant_vld)
    );

    // Readiness is judged against registered state only, so same-cycle frees are never reused.
    always_comb begin
        resolve      = br_upd_if.update & ~br_upd_if.dead;
        kill_cyc     = resolve & br_upd_if.mispredict;
        n_br         = CNT_W'(popcount(brmask_t'(i_disp_is_br)));
        o_disp_ready = (n_br <= r_free_count) & ~kill_cyc;
        accept       = i_disp_valid & o_disp_ready;
        o_free_count = r_free_count;
    end

    // Per-slot tag encode and mask: unresolved tags plus tags given to earlier branch slots.
    always_comb begin
        mask_run       = r_unres;
        o_disp_brtag   = '0;
        o_disp_br_mask = '0;
        for (int i = 0; i < DISP_SIZE; i++) begin
            o_disp_br_mask[i] = mask_run;
            for (int t = 0; t < ENTRY_SIZE; t++) begin
                if (grant_oh[i][t]) begin
                    o_disp_brtag[i] = brtag_t'(t);
                end
            end
            mask_run = mask_run | grant_oh[i];
        end
    end

    // Next state: allocation first, then resolve/kill/commit so frees always win over allocation.
    always_comb begin
        w_alloc = r_alloc;
        w_unres = r_unres;
        w_dep   = r_dep;

        if (accept) begin
            for (int i = 0; i < DISP_SIZE; i++) begin
                if (grant_vld[i]) begin
                    w_alloc                = w_alloc | grant_oh[i];
                    w_unres                = w_unres | grant_oh[i];
                    w_dep[o_disp_brtag[i]] = o_disp_br_mask[i];
                end
            end
        end

        if (resolve) begin
            w_unres[br_upd_if.brtag] = 1'b0;
            for (int t = 0; t < ENTRY_SIZE; t++) begin
                w_dep[t][br_upd_if.brtag] = 1'b0;
            end
        end

        // Younger branches carry the mispredicting tag in their allocation snapshot.
        if (kill_cyc) begin
            for (int t = 0; t < ENTRY_SIZE; t++) begin
                if (r_dep[t][br_upd_if.brtag]) begin
                    w_alloc[t] = 1'b0;
                    w_unres[t] = 1'b0;
                    w_dep[t]   = '0;
                end
            end
        end

        if (cmt_brtag_if.commit) begin
            for (int i = 0; i < DISP_SIZE; i++) begin
                if (cmt_brtag_if.is_br_inst[i]) begin
                    w_alloc[cmt_brtag_if.brtag[i]] = 1'b0;
                    w_unres[cmt_brtag_if.brtag[i]] = 1'b0;
                    w_dep[cmt_brtag_if.brtag[i]]   = '0;
                end
            end
        end

        w_free_count = CNT_W'(ENTRY_SIZE - int'(popcount(w_alloc)));
    end

    // Tag state registers; reset drops every allocation immediately.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_alloc      <= '0;
            r_unres      <= '0;
            r_dep        <= '0;
            r_free_count <= CNT_W'(ENTRY_SIZE);
        end else begin
            r_alloc      <= w_alloc;
            r_unres      <= w_unres;
            r_dep        <= w_dep;
            r_free_count <= w_free_count;
        end
    end

`ifndef SYNTHESIS
    // Protocol sanity: commits and resolutions must target live tags; free count must track r_alloc.
    always_ff @(posedge i_clk) begin
        if (i_reset_n) begin
            if (cmt_brtag_if.commit) begin
                for (int i = 0; i < DISP_SIZE; i++) begin
                    if (cmt_brtag_if.is_br_inst[i]) begin
                        assert (r_alloc[cmt_brtag_if.brtag[i]])
                        else $error("brtag_alloc: commit of free tag %0d", cmt_brtag_if.brtag[i]);
                    end
                end
            end
            if (resolve) begin
                assert (r_alloc[br_upd_if.brtag])
                else $error("brtag_alloc: br_upd of free tag %0d", br_upd_if.brtag);
            end
            assert (r_free_count == CNT_W'(ENTRY_SIZE - int'(popcount(r_alloc))))
            else $error("brtag_alloc: free count %0d inconsistent with alloc vector", r_free_count);
        end
    end
`endif

endmodule

// File: doc/msrh_brtag_alloc.md
Name: msrh_brtag_alloc

Overview:
- Consumer end of the branch-update and branch-commit interfaces.
- Allocates branch tags to branches at dispatch and produces the per-instruction br_mask.
- Clears resolved tags from the mask on br_upd, kills younger tags on mispredict, frees tags on commit via cmt_brtag_if.
- Sits between decode/dispatch and the BRU reservation station.

Parameters:
- ENTRY_SIZE, msrh_conf_pkg::RV_BRU_ENTRY_SIZE (16): number of branch tags; must be >= DISP_SIZE.
- DISP_SIZE, msrh_conf_pkg::DISP_SIZE (5): dispatch group width.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_disp_valid  in  1  dispatch group valid.
- i_disp_is_br  in  DISP_SIZE  per-slot branch flag.
- o_disp_ready  out  1  group can be accepted (enough free tags).
- o_disp_brtag  out  DISP_SIZE x brtag_t  tag assigned per slot (0 when slot is not a branch).
- o_disp_br_mask  out  DISP_SIZE x brmask_t  unresolved older-branch mask per slot.
- br_upd_if  slave  bundle  branch resolution from BRU (update, mispredict, dead, brtag used).
- cmt_brtag_if  slave  bundle  commit, is_br_inst, brtag per slot.
- o_free_count  out  $clog2(ENTRY_SIZE)+1  registered number of free tags.

Behaviour:
State (all flops reset asynchronously on i_reset_n low):
- r_alloc[ENTRY_SIZE]: tag in use.
- r_unres[ENTRY_SIZE]: tag allocated and not yet resolved.
- r_dep[ENTRY_SIZE][ENTRY_SIZE]: r_unres snapshot taken when the tag was allocated.

Reset values:
- r_alloc = 0, r_unres = 0, r_dep = 0.
- o_free_count = ENTRY_SIZE, o_disp_ready = 1.
- o_disp_brtag = 0, o_disp_br_mask = 0.

Allocation (combinational select, registered update):
- n_br = popcount(i_disp_is_br).
- o_disp_ready = (n_br <= o_free_count) & ~kill_cyc. Acceptance is all-or-nothing.
- Free tags are picked lowest-index first, assigned to branch slots in ascending slot order.
- o_disp_br_mask[i] = r_unres | tags assigned to branch slots j<i in the same group.
- On accept (i_disp_valid & o_disp_ready), each assigned tag t is registered next cycle: r_alloc[t]=1, r_unres[t]=1, r_dep[t]=o_disp_br_mask[slot].
- Tags freed this cycle are not visible as free until the next cycle; free count uses registered state only.

Resolve (br_upd_if.update & ~dead):
- Next cycle r_unres[brtag]=0, and bit brtag is cleared in every r_dep row.
- Mispredict additionally defines kill_cyc = update & mispredict & ~dead.
- On kill_cyc, every tag t with r_dep[t][brtag]=1 is freed next cycle (r_alloc=0, r_unres=0, r_dep row=0).
- The mispredicting tag itself stays allocated until commit.
- o_disp_ready is forced 0 during kill_cyc; dispatch in that cycle is dropped.

Commit:
- For each slot i with commit & is_br_inst[i], tag brtag[i] is freed next cycle.
- Multiple commits per cycle are allowed.

Simultaneous events and boundaries:
- Free actions (commit, kill) and resolve are applied after allocation in the same update, so a tag can never be both freed and allocated in one cycle.
- Killing and committing the same tag in one cycle is idempotent.
- Full: o_free_count=0 -> ready only if n_br=0 (a group with no branches always passes except during kill_cyc).
- Tag indices wrap with no ordering assumption; age is carried only by r_dep.

SIMULATION-only assertions:
- Commit of a free tag.
- br_upd of a free tag.
- o_free_count mismatch against popcount(~r_alloc).

Reset mid-operation: all state returns to reset values immediately; no pending frees are retained.

Decomposition:
- In msrh_pkg: brtag_t and brmask_t (already used by br_upd_if), plus a popcount function and BRTAG_W.
- One natural sub-module, msrh_brtag_pick: a multi-way lowest-first free-bit picker that takes the free vector and DISP_SIZE requests and returns per-slot one-hot tags and a valid flag.

Test Plan:
- Reset then group is_br=5'b00101 -> ready=1; slot0 tag0 mask 0; slot2 tag1 mask 0x0001; next cycle free_count=14.
- Allocate tags 0,1,2 in separate cycles, then br_upd mispredict on tag0 -> tags 1,2 freed next cycle, tag0 held; dispatch ready=0 during the mispredict cycle.
- br_upd non-mispredict on tag0 -> next dispatch br_mask omits bit0, and a later mispredict on tag1 does not kill tags allocated before tag1.
- Fill all 16 tags -> free_count=0, branch group ready=0, non-branch group ready=1; commit tag3 -> free_count=1 next cycle, and the next one-branch group gets tag3.
- Same-cycle commit of tag5 plus mispredict killing tag5 plus a new dispatch -> tag5 not reassigned that cycle, free count correct next cycle, no assertion.
- Assert i_reset_n low while 10 tags are in flight -> free_count=16 and all masks 0 immediately.
